// File: rtl/ef_ahbl_master.sv
// AHB-Lite initiator: turns a valid/ready command stream into single NONSEQ transfers, one response per command.
// Optional macro EF_AHBL_MASTER_ERR_CANCEL_EN holds back the queued address phase for one cycle after an error response.
module ef_ahbl_master (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_write,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  logic        vld_p0;
  logic        wr_p0;
  logic [31:0] addr_p0;
  logic [2:0]  size_p0;
  logic [31:0] wdata_p0;

  logic        vld_p1;
  logic        wr_p1;
  logic [31:0] wdata_p1;

  logic        vld_p2;
  logic        wr_p2;
  logic [31:0] rdata_p2;
  logic        err_p2;

  logic        err_hold;
  logic        cmd_fire;
  logic        done_p1;

  assign cmd_ready = ~vld_p0 | (HREADY & ~err_hold);
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign done_p1   = vld_p1 & HREADY;

  // Stage p0: address phase. An empty stage may be filled even during a wait state.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      vld_p0   <= 1'b0;
      wr_p0    <= 1'b0;
      addr_p0  <= '0;
      size_p0  <= '0;
      wdata_p0 <= '0;
    end else if (cmd_fire) begin
      vld_p0   <= 1'b1;
      wr_p0    <= cmd_write;
      addr_p0  <= cmd_addr;
      size_p0  <= cmd_size;
      wdata_p0 <= cmd_wdata;
    end else if (HREADY & ~err_hold) begin
      vld_p0   <= 1'b0;
    end
  end

  // Stage p1: data phase, advances only when the bus is ready.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      vld_p1   <= 1'b0;
      wr_p1    <= 1'b0;
      wdata_p1 <= '0;
    end else if (HREADY) begin
      vld_p1   <= vld_p0 & ~err_hold;
      wr_p1    <= wr_p0;
      wdata_p1 <= wdata_p0;
    end
  end

  // Stage p2: one-cycle response pulse after the data phase completes.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      vld_p2   <= 1'b0;
      wr_p2    <= 1'b0;
      rdata_p2 <= '0;
      err_p2   <= 1'b0;
    end else begin
      vld_p2   <= done_p1;
      wr_p2    <= done_p1 & wr_p1;
      rdata_p2 <= (done_p1 & ~wr_p1) ? HRDATA : 32'h0;
      err_p2   <= done_p1 & HRESP;
    end
  end

`ifdef EF_AHBL_MASTER_ERR_CANCEL_EN
  // First error cycle (HREADY low) arms the hold; it drops on the closing edge.
  always_ff @(posedge HCLK) begin
    if (HRESET)
      err_hold <= 1'b0;
    else if (HREADY)
      err_hold <= 1'b0;
    else if (vld_p1 & HRESP)
      err_hold <= 1'b1;
  end
`else
  assign err_hold = 1'b0;
`endif

  assign HTRANS    = (vld_p0 & ~err_hold) ? 2'b10 : 2'b00;
  assign HADDR     = addr_p0;
  assign HWRITE    = wr_p0;
  assign HSIZE     = size_p0;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HWDATA    = wdata_p1;

  assign rsp_valid = vld_p2;
  assign rsp_write = wr_p2;
  assign rsp_rdata = rdata_p2;
  assign rsp_err   = err_p2;
  assign busy      = vld_p0 | vld_p1;

endmodule

// File: tb/tb_ef_ahbl_master.sv
// Scoreboard bench for ef_ahbl_master: memory-backed AHB-Lite slave model plus an in-order reference memory.
`timescale 1ns/1ps
module tb_ef_ahbl_master;

  logic        HCLK;
  logic        HRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_write, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  ef_ahbl_master dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  typedef struct { logic wr; logic [31:0] rdata; logic err; } rsp_t;
  typedef struct { logic wr; logic [31:0] addr; logic [2:0] size; } aph_t;
  rsp_t exp_q[$];
  aph_t aph_q[$];

  // Slave behaviour: word memory indexed by addr[7:2], error response for words flagged in err_map,
  // erroring writes leave memory untouched. mmem is the reference model's view, smem the slave's.
  logic [31:0] smem [64];
  logic [31:0] mmem [64];
  bit          err_map [64];

  logic        s_rst, s_valid, s_write;
  logic [31:0] s_addr, s_wdata;
  logic [2:0]  s_size;
  int          wait_min, wait_max;
  bit          hs;

  bit          sl_act, sl_wr, sl_err, sl_errc;
  int          sl_wait;
  logic [5:0]  sl_idx;

  task automatic model_cmd(input logic wr, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    rsp_t r;
    aph_t p;
    logic [5:0] idx;
    idx     = a[7:2];
    r.wr    = wr;
    r.err   = err_map[idx];
    r.rdata = wr ? 32'h0 : mmem[idx];
    if (wr && !err_map[idx]) mmem[idx] = d;
    exp_q.push_back(r);
    p.wr = wr; p.addr = a; p.size = sz;
    aph_q.push_back(p);
  endtask

  task automatic step();
    aph_t a;
    @(negedge HCLK);
    HRESET    = s_rst;
    cmd_valid = s_valid;
    cmd_write = s_write;
    cmd_addr  = s_addr;
    cmd_size  = s_size;
    cmd_wdata = s_wdata;
    HRESP     = sl_act && sl_err;
    HREADY    = !sl_act || (sl_err ? sl_errc : (sl_wait == 0));
    HRDATA    = (sl_act && !sl_wr) ? smem[sl_idx] : $urandom;
    #1;
    hs = !s_rst && cmd_valid && cmd_ready;
    if (hs) model_cmd(cmd_write, cmd_addr, cmd_size, cmd_wdata);
    if (s_rst) begin
      sl_act = 0;
    end else if (HREADY) begin
      if (sl_act && sl_wr && !sl_err) smem[sl_idx] = HWDATA;
      sl_act = 0;
      if (HTRANS == 2'b10) begin
        if (aph_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL aph_unexpected: got NONSEQ to %h, required no transfer", HADDR);
        end else begin
          a = aph_q.pop_front();
          check("aph_haddr", HADDR, a.addr);
          check("aph_hwrite", 32'(HWRITE), 32'(a.wr));
          check("aph_hsize", 32'(HSIZE), 32'(a.size));
        end
        sl_act  = 1;
        sl_wr   = HWRITE;
        sl_idx  = HADDR[7:2];
        sl_err  = err_map[HADDR[7:2]];
        sl_errc = 0;
        sl_wait = $urandom_range(wait_max, wait_min);
      end
    end else if (sl_act) begin
      if (sl_err) sl_errc = 1;
      else sl_wait--;
    end
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    s_valid = 1; s_write = wr; s_addr = a; s_size = sz; s_wdata = d;
    hs = 0;
    for (int i = 0; i < 50 && !hs; i++) step();
    if (!hs) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: got no handshake for addr %h, required one within 50 cycles", a);
    end
    s_valid = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (exp_q.size() != 0 || aph_q.size() != 0); i++) step();
    check("drain_rsp_left", 32'(exp_q.size()), 32'h0);
    check("drain_aph_left", 32'(aph_q.size()), 32'h0);
  endtask

  // Monitor: every response pulse is matched in order against the scoreboard.
  always @(negedge HCLK) begin
    rsp_t r;
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 rdata=%h, required no response", rsp_rdata);
      end else begin
        r = exp_q.pop_front();
        check("rsp_write", 32'(rsp_write), 32'(r.wr));
        check("rsp_rdata", rsp_rdata, r.rdata);
        check("rsp_err", 32'(rsp_err), 32'(r.err));
      end
    end
  end

  initial begin
    logic [31:0] rnd;
    for (int i = 0; i < 64; i++) begin smem[i] = '0; mmem[i] = '0; err_map[i] = 0; end
    s_rst = 1; s_valid = 0; s_write = 0; s_addr = '0; s_size = '0; s_wdata = '0;
    wait_min = 0; wait_max = 0;
    sl_act = 0; sl_wr = 0; sl_err = 0; sl_errc = 0; sl_wait = 0; sl_idx = '0;
    HRESET = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_size = '0; cmd_wdata = '0;
    HREADY = 1; HRESP = 0; HRDATA = '0;

    // Reset state
    step(); step();
    check("rst_htrans", 32'(HTRANS), 32'h0);
    check("rst_haddr", HADDR, 32'h0);
    check("rst_hwrite", 32'(HWRITE), 32'h0);
    check("rst_hsize", 32'(HSIZE), 32'h0);
    check("rst_hwdata", HWDATA, 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    s_rst = 0;
    step();

    // Single zero-wait write: NONSEQ at +1, data at +2, response at +3
    issue(1'b1, 32'h10, 3'd2, 32'h3F);
    step();
    check("w1_htrans", 32'(HTRANS), 32'h2);
    check("w1_haddr", HADDR, 32'h10);
    step();
    check("w1_hwdata", HWDATA, 32'h3F);
    check("w1_rsp_early", 32'(rsp_valid), 32'h0);
    step();
    check("w1_rsp_valid", 32'(rsp_valid), 32'h1);
    check("w1_rsp_write", 32'(rsp_write), 32'h1);
    check("w1_rsp_err", 32'(rsp_err), 32'h0);
    check("w1_rsp_rdata", rsp_rdata, 32'h0);
    drain();

    // Back-to-back reads with overlapped address/data phases
    smem[0] = 32'h11; mmem[0] = 32'h11;
    smem[1] = 32'h22; mmem[1] = 32'h22;
    issue(1'b0, 32'h0, 3'd2, 32'h0);
    issue(1'b0, 32'h4, 3'd2, 32'h0);
    step();
    check("rr_haddr2", HADDR, 32'h4);
    check("rr_htrans2", 32'(HTRANS), 32'h2);
    step();
    check("rr_rsp1_valid", 32'(rsp_valid), 32'h1);
    check("rr_rsp1_rdata", rsp_rdata, 32'h11);
    step();
    check("rr_rsp2_valid", 32'(rsp_valid), 32'h1);
    check("rr_rsp2_rdata", rsp_rdata, 32'h22);
    drain();

    // Write with three wait states and a read queued behind it
    wait_min = 3; wait_max = 3;
    issue(1'b1, 32'h8, 3'd2, 32'hDEADBEEF);
    issue(1'b0, 32'hC, 3'd2, 32'h0);
    for (int c = 0; c < 4; c++) begin
      step();
      check("ws_hwdata", HWDATA, 32'hDEADBEEF);
      check("ws_cmd_ready", 32'(cmd_ready), (c < 3) ? 32'h0 : 32'h1);
      check("ws_rsp_early", 32'(rsp_valid), 32'h0);
    end
    step();
    check("ws_rsp_valid", 32'(rsp_valid), 32'h1);
    check("ws_rsp_write", 32'(rsp_write), 32'h1);
    drain();
    wait_min = 0; wait_max = 0;

    // Error response on the first of two writes
    err_map[0] = 1;
    issue(1'b1, 32'h0, 3'd2, 32'hA5A5A5A5);
    issue(1'b1, 32'h4, 3'd2, 32'h5A5A5A5A);
    step();
    check("er_htrans_c2", 32'(HTRANS), 32'h2);
    check("er_haddr_c2", HADDR, 32'h4);
    step();
`ifdef EF_AHBL_MASTER_ERR_CANCEL_EN
    check("er_htrans_c3", 32'(HTRANS), 32'h0);
`else
    check("er_htrans_c3", 32'(HTRANS), 32'h2);
`endif
    step();
    check("er_rsp_valid", 32'(rsp_valid), 32'h1);
    check("er_rsp_err", 32'(rsp_err), 32'h1);
`ifdef EF_AHBL_MASTER_ERR_CANCEL_EN
    check("er_reissue_htrans", 32'(HTRANS), 32'h2);
    check("er_reissue_haddr", HADDR, 32'h4);
`else
    check("er_htrans_c4", 32'(HTRANS), 32'h0);
`endif
    drain();
    err_map[0] = 0;

    // Reset during a read wait state drops the read silently
    wait_min = 3; wait_max = 3;
    issue(1'b0, 32'h20, 3'd2, 32'h0);
    step();
    s_rst = 1;
    step();
    s_rst = 0;
    step();
    check("rm_htrans", 32'(HTRANS), 32'h0);
    check("rm_busy", 32'(busy), 32'h0);
    check("rm_rsp_valid", 32'(rsp_valid), 32'h0);
    exp_q.delete();
    aph_q.delete();
    for (int c = 0; c < 5; c++) begin
      step();
      check("rm_no_rsp", 32'(rsp_valid), 32'h0);
    end
    wait_min = 0; wait_max = 0;
    smem[9] = 32'h0BADF00D; mmem[9] = 32'h0BADF00D;
    issue(1'b0, 32'h24, 3'd2, 32'h0);
    drain();

    // Idle bus
    for (int c = 0; c < 10; c++) begin
      step();
      check("idle_htrans", 32'(HTRANS), 32'h0);
      check("idle_hburst", 32'(HBURST), 32'h0);
      check("idle_hprot", 32'(HPROT), 32'h3);
      check("idle_rsp_valid", 32'(rsp_valid), 32'h0);
    end

    // Randomized traffic with waits, errors and gaps
    for (int i = 0; i < 64; i++) err_map[i] = ($urandom_range(7, 0) == 0);
    wait_min = 0; wait_max = 2;
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(3, 0) == 0) step();
      rnd = $urandom;
      issue(rnd[0], 32'($urandom_range(63, 0)) << 2, 3'($urandom_range(2, 0)), $urandom);
    end
    drain();
    check("end_busy", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ef_ahbl_master.md
Name: ef_ahbl_master

Overview:
- Single-port AHB-Lite initiator (master). Turns a simple valid/ready command stream into AHB-Lite single transfers and returns one response per command.
- Address phase of command N+1 overlaps the data phase of command N.
- Used by test/DMA-style logic to drive ef_* AHB-Lite peripherals such as the PWM, timer and UART wrappers.

Parameters:
- none

Ports:
- HCLK  in  1  clock
- HRESET  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted this cycle when cmd_valid&cmd_ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  32  byte address; must be aligned to cmd_size
- cmd_size  in  3  HSIZE encoding, 0..2 only
- cmd_wdata  in  32  write data
- rsp_valid  out  1  one-cycle pulse, one per accepted command, in order
- rsp_write  out  1  type of the completed command
- rsp_rdata  out  32  read data; 0 for writes
- rsp_err  out  1  slave returned HRESP=1
- busy  out  1  any transfer in address or data stage
- HADDR  out  32  AHB address
- HTRANS  out  2  00 IDLE or 10 NONSEQ only
- HWRITE  out  1  AHB write
- HSIZE  out  3  AHB size
- HBURST  out  3  constant 000 (SINGLE)
- HPROT  out  4  constant 0011
- HWDATA  out  32  AHB write data
- HRDATA  in  32  AHB read data
- HREADY  in  1  transfer-done / bus-ready
- HRESP  in  1  error response

Behaviour:
- Two register stages:
  - A (address phase): a_valid, write, addr, size, wdata.
  - D (data phase): d_valid, write, wdata.
- Reset (sync, HRESET=1 at a rising edge) clears a_valid, d_valid and err_hold.
  - Outputs after reset: HTRANS=00, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=0, cmd_ready=1.
  - Reset mid-transfer drops both stages with no response. The requester must treat in-flight commands as lost.
- Address outputs come from stage A:
  - HTRANS=10 when a_valid & ~err_hold, else 00.
  - HADDR/HWRITE/HSIZE hold their last values when idle.
- HWDATA=D.wdata, stable for the whole data phase including wait states.
- cmd_ready = ~a_valid | (HREADY & ~err_hold). It is combinational from HREADY.
- At an edge with HREADY=1:
  - D <= A; d_valid <= a_valid & ~err_hold.
  - If the command handshake fires, A <= cmd; else a_valid clears, unless err_hold retained it.
- Completion: at an edge with d_valid & HREADY=1, the next cycle has:
  - rsp_valid=1, rsp_write=D.write, rsp_err=HRESP (sampled), rsp_rdata=HRDATA for reads, 0 for writes.
  - Response latency: 1 cycle after the data phase ends. Minimum command-to-response time is 3 cycles with zero wait states.
  - Back-to-back zero-wait commands give one response per cycle.
- Wait states (HREADY=0): all stages hold; cmd_ready=0 if a_valid.
- Error (HRESP=1): two-cycle response; the first cycle has HREADY=0, the second HREADY=1. The D command completes with rsp_err=1 and the block continues normally.
- No response backpressure. The consumer must sample rsp_* whenever rsp_valid=1.
- busy = a_valid | d_valid.
- cmd_size>2 or a misaligned address are not checked; they are driven to the bus as given.

Optional Feature:
- Macro: EF_AHBL_MASTER_ERR_CANCEL_EN.
- Defined:
  - At an edge where d_valid & HRESP & ~HREADY (first error cycle), set err_hold=1. It clears at the next edge where HREADY=1.
  - While err_hold=1, HTRANS is forced to 00 and the pending A command is retained, not advanced.
  - The pending A command is re-presented as NONSEQ in the following cycle.
  - The A command is never lost; it only costs one extra cycle.
- Undefined: err_hold is tied to 0 and the pending A transfer proceeds unchanged.

Test Plan:
- Write 0x0000_0010 <= 0x0000_003F, zero wait. Required:
  - NONSEQ at cycle 1, HWDATA=0x3F at cycle 2.
  - rsp_valid at cycle 3 with rsp_write=1, rsp_err=0, rsp_rdata=0.
- Back-to-back read of 0x0 then 0x4, slave returning 0x11 and 0x22. Required:
  - Second HADDR=0x4 coincides with the first data phase.
  - rsp pulses on consecutive cycles: 0x11 then 0x22.
- Write 0x8 <= 0xDEADBEEF with 3 wait states. Required:
  - HWDATA stable for 4 cycles; cmd_ready=0 while a queued read is pending.
  - Single rsp on the cycle after HREADY rises.
- Error on the first of two writes (0x0, 0x4). Required:
  - rsp_err=1 then rsp_err=0.
  - With EF_AHBL_MASTER_ERR_CANCEL_EN: HTRANS=00 in the second error cycle, then 0x4 re-issued as NONSEQ.
  - Without the macro: 0x4 NONSEQ is continuous.
- HRESET asserted during a read wait state. Required:
  - Next cycle: HTRANS=00, busy=0, no rsp_valid.
  - A new read afterwards completes normally.
- Idle bus: cmd_valid=0 for 10 cycles. Required: HTRANS=00, HBURST=000, HPROT=0011, rsp_valid=0 throughout.
